// File: rtl/axilite_timer_pkg.sv
// Shared definitions for the AXI-Lite programmable timer: register map,
// control bit positions, response codes and bus FSM states.
package axilite_timer_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned PSC_W  = 16;
   localparam int unsigned CTRL_W = 3;

   // Byte offsets; only addr[4:2] is decoded, so offsets are word aligned
   localparam logic [4:0] OFF_CTRL      = 5'h00;
   localparam logic [4:0] OFF_PRESCALER = 5'h04;
   localparam logic [4:0] OFF_COUNTER   = 5'h08;
   localparam logic [4:0] OFF_COMPARE   = 5'h0C;
   localparam logic [4:0] OFF_STATUS    = 5'h10;

   localparam int unsigned CTRL_EN         = 0;
   localparam int unsigned CTRL_AUTORELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN     = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } axi_resp_e;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   // Byte-lane merge of a write into an existing register value
   function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] r;
      r = old_v;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/axilite_timer_if.sv
// AXI-Lite slave bus bundle for the timer peripheral.
interface axilite_timer_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axilite_timer_core.sv
// Timer datapath: prescaler, up-counter, compare match and pending flag.
module axilite_timer_core
   import axilite_timer_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic              en,
   input  logic              autoreload,
   input  logic [PSC_W-1:0]  prescaler,
   input  logic [DATA_W-1:0] compare,
   input  logic              prescaler_we,
   input  logic              counter_we,
   input  logic [DATA_W-1:0] counter_wdata,
   input  logic              pending_clr,
   output logic [DATA_W-1:0] counter,
   output logic              pending,
   output logic              en_clr_c
);
   logic [PSC_W-1:0] psc_q;
   logic             tick_c;
   logic             match_c;

   assign tick_c   = en & (psc_q == prescaler);
   assign match_c  = tick_c & (counter == compare);
   assign en_clr_c = match_c & ~autoreload;

   // Software writes take priority over the hardware count; a match set beats a clear
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         psc_q   <= '0;
         counter <= '0;
         pending <= 1'b0;
      end else begin
         if (prescaler_we)  psc_q <= '0;
         else if (en)       psc_q <= tick_c ? '0 : psc_q + PSC_W'(1);

         if (counter_we)    counter <= counter_wdata;
         else if (tick_c)   counter <= match_c ? (autoreload ? '0 : counter)
                                               : counter + DATA_W'(1);

         if (match_c)          pending <= 1'b1;
         else if (pending_clr) pending <= 1'b0;
      end
   end
endmodule

// File: rtl/axilite_timer.sv
// AXI-Lite programmable timer: bus write/read FSMs and register file around
// the timer core; int_o is a level interrupt toward the PLIC.
module axilite_timer
   import axilite_timer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   axilite_timer_if.slave    s_axilite,
   output logic              int_o
);
   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("axilite_timer: DATA_WIDTH must be 32");
   end

   logic [CTRL_W-1:0] ctrl_q;
   logic [PSC_W-1:0]  presc_q;
   logic [DATA_W-1:0] compare_q;
   logic [DATA_W-1:0] counter;
   logic              pending;
   logic              en_clr_c;

   wr_state_e         wr_state_q;
   rd_state_e         rd_state_q;
   logic              aw_got_q, w_got_q;
   logic [4:0]        aw_off_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;

   logic              aw_hs_c, w_hs_c, ar_hs_c, wr_fire_c;
   logic [4:0]        wr_off_c, rd_off_c;
   logic [DATA_W-1:0] wr_data_c;
   logic [STRB_W-1:0] wr_strb_c;
   logic [DATA_W-1:0] rd_data_c;
   axi_resp_e         rd_resp_c;

   logic unused_c;
   assign unused_c = ^{s_axilite.awprot, s_axilite.arprot,
                       s_axilite.awaddr[ADDR_WIDTH-1:5], s_axilite.awaddr[1:0],
                       s_axilite.araddr[ADDR_WIDTH-1:5], s_axilite.araddr[1:0]};

   assign aw_hs_c   = s_axilite.awvalid & s_axilite.awready;
   assign w_hs_c    = s_axilite.wvalid & s_axilite.wready;
   assign ar_hs_c   = s_axilite.arvalid & s_axilite.arready;
   assign wr_fire_c = (wr_state_q == W_IDLE) & (aw_got_q | aw_hs_c) & (w_got_q | w_hs_c);

   // Use the live bus value for whichever half arrives in the firing cycle
   assign wr_off_c  = aw_got_q ? aw_off_q : {s_axilite.awaddr[4:2], 2'b00};
   assign wr_data_c = w_got_q ? wdata_q : s_axilite.wdata;
   assign wr_strb_c = w_got_q ? wstrb_q : s_axilite.wstrb;
   assign rd_off_c  = {s_axilite.araddr[4:2], 2'b00};

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_state_q          <= W_IDLE;
         s_axilite.awready   <= 1'b0;
         s_axilite.wready    <= 1'b0;
         s_axilite.bvalid    <= 1'b0;
         s_axilite.bresp     <= RESP_OKAY;
         aw_got_q            <= 1'b0;
         w_got_q             <= 1'b0;
         aw_off_q            <= '0;
         wdata_q             <= '0;
         wstrb_q             <= '0;
      end else begin
         case (wr_state_q)
            W_IDLE: begin
               if (aw_hs_c) begin
                  aw_got_q <= 1'b1;
                  aw_off_q <= {s_axilite.awaddr[4:2], 2'b00};
               end
               if (w_hs_c) begin
                  w_got_q <= 1'b1;
                  wdata_q <= s_axilite.wdata;
                  wstrb_q <= s_axilite.wstrb;
               end
               if (wr_fire_c) begin
                  wr_state_q        <= W_RESP;
                  s_axilite.bvalid  <= 1'b1;
                  s_axilite.bresp   <= (wr_off_c <= OFF_STATUS) ? RESP_OKAY : RESP_SLVERR;
                  s_axilite.awready <= 1'b0;
                  s_axilite.wready  <= 1'b0;
                  aw_got_q          <= 1'b0;
                  w_got_q           <= 1'b0;
               end else begin
                  s_axilite.awready <= ~(aw_got_q | aw_hs_c);
                  s_axilite.wready  <= ~(w_got_q | w_hs_c);
               end
            end
            W_RESP: begin
               if (s_axilite.bready) begin
                  wr_state_q        <= W_IDLE;
                  s_axilite.bvalid  <= 1'b0;
                  s_axilite.awready <= 1'b1;
                  s_axilite.wready  <= 1'b1;
               end
            end
            default: wr_state_q <= W_IDLE;
         endcase
      end
   end

   // Register file; a CTRL write in the one-shot match cycle keeps the written EN
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ctrl_q    <= '0;
         presc_q   <= '0;
         compare_q <= '0;
      end else begin
         if (wr_fire_c && wr_off_c == OFF_CTRL)
            ctrl_q <= CTRL_W'(apply_wstrb(DATA_W'(ctrl_q), wr_data_c, wr_strb_c));
         else if (en_clr_c)
            ctrl_q[CTRL_EN] <= 1'b0;
         if (wr_fire_c && wr_off_c == OFF_PRESCALER)
            presc_q <= PSC_W'(apply_wstrb(DATA_W'(presc_q), wr_data_c, wr_strb_c));
         if (wr_fire_c && wr_off_c == OFF_COMPARE)
            compare_q <= apply_wstrb(compare_q, wr_data_c, wr_strb_c);
      end
   end

   axilite_timer_core u_core (
      .clock_i       (clock_i),
      .reset_ni      (reset_ni),
      .en            (ctrl_q[CTRL_EN]),
      .autoreload    (ctrl_q[CTRL_AUTORELOAD]),
      .prescaler     (presc_q),
      .compare       (compare_q),
      .prescaler_we  (wr_fire_c && wr_off_c == OFF_PRESCALER),
      .counter_we    (wr_fire_c && wr_off_c == OFF_COUNTER),
      .counter_wdata (apply_wstrb(counter, wr_data_c, wr_strb_c)),
      .pending_clr   (wr_fire_c && wr_off_c == OFF_STATUS && wr_data_c[0] && wr_strb_c[0]),
      .counter       (counter),
      .pending       (pending),
      .en_clr_c      (en_clr_c)
   );

   always_comb begin
      rd_data_c = '0;
      rd_resp_c = RESP_OKAY;
      case (rd_off_c)
         OFF_CTRL:      rd_data_c = DATA_W'(ctrl_q);
         OFF_PRESCALER: rd_data_c = DATA_W'(presc_q);
         OFF_COUNTER:   rd_data_c = counter;
         OFF_COMPARE:   rd_data_c = compare_q;
         OFF_STATUS:    rd_data_c = DATA_W'(pending);
         default:       rd_resp_c = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rd_state_q        <= R_IDLE;
         s_axilite.arready <= 1'b0;
         s_axilite.rvalid  <= 1'b0;
         s_axilite.rdata   <= '0;
         s_axilite.rresp   <= RESP_OKAY;
      end else begin
         case (rd_state_q)
            R_IDLE: begin
               if (ar_hs_c) begin
                  rd_state_q        <= R_DATA;
                  s_axilite.arready <= 1'b0;
                  s_axilite.rvalid  <= 1'b1;
                  s_axilite.rdata   <= rd_data_c;
                  s_axilite.rresp   <= rd_resp_c;
               end else begin
                  s_axilite.arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axilite.rready) begin
                  rd_state_q        <= R_IDLE;
                  s_axilite.rvalid  <= 1'b0;
                  s_axilite.arready <= 1'b1;
               end
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   assign int_o = pending & ctrl_q[CTRL_IRQ_EN];
endmodule

// File: tb/tb_axilite_timer.sv
// Bench for axilite_timer: directed and random AXI-Lite traffic against a
// cycle-level reference model, with a scoreboard matching bus responses.
module tb_axilite_timer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic int_o;
   always #5 clk = ~clk;

   axilite_timer_if bus ();

   axilite_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .s_axilite(bus.slave),
      .int_o    (int_o)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rsp_t;

   rsp_t        rd_q[$];
   logic [1:0]  wr_q[$];

   // Reference model state, named after the programmer-visible registers
   bit          m_en, m_ar, m_irq, m_pend;
   int unsigned m_psc;
   logic [15:0] m_presc;
   logic [31:0] m_cnt, m_cmp;
   bit          m_aw_got, m_w_got;
   logic [2:0]  m_aw_idx;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   function automatic rsp_t model_read(input logic [2:0] idx);
      rsp_t r;
      r.data = 32'h0;
      r.resp = 2'b00;
      case (idx)
         3'd0: r.data = {29'h0, m_irq, m_ar, m_en};
         3'd1: r.data = {16'h0, m_presc};
         3'd2: r.data = m_cnt;
         3'd3: r.data = m_cmp;
         3'd4: r.data = {31'h0, m_pend};
         default: r.resp = 2'b10;
      endcase
      return r;
   endfunction

   // Model: predict the effect of the coming rising edge from the bus as it stands now
   always @(negedge clk) begin
      bit          tick, match, wr;
      logic [31:0] ctrl_new;
      if (!rst_n) begin
         m_en = 0; m_ar = 0; m_irq = 0; m_pend = 0;
         m_psc = 0; m_presc = '0; m_cnt = '0; m_cmp = '0;
         m_aw_got = 0; m_w_got = 0; m_aw_idx = '0; m_wdata = '0; m_wstrb = '0;
      end else begin
         chk("int_o", 32'(int_o), 32'(m_pend & m_irq));
         if (bus.awvalid && bus.awready) begin
            m_aw_got = 1; m_aw_idx = bus.awaddr[4:2];
         end
         if (bus.wvalid && bus.wready) begin
            m_w_got = 1; m_wdata = bus.wdata; m_wstrb = bus.wstrb;
         end
         wr = m_aw_got && m_w_got;
         if (bus.arvalid && bus.arready) rd_q.push_back(model_read(bus.araddr[4:2]));

         tick  = m_en && (m_psc == 32'(m_presc));
         match = tick && (m_cnt == m_cmp);
         if (m_en) m_psc = tick ? 0 : m_psc + 1;
         if (tick) begin
            if (match) begin
               m_pend = 1;
               if (m_ar) m_cnt = 0;
               else      m_en = 0;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end

         if (wr) begin
            case (m_aw_idx)
               3'd0: begin
                  ctrl_new = merge({29'h0, m_irq, m_ar, m_en}, m_wdata, m_wstrb);
                  m_en = ctrl_new[0]; m_ar = ctrl_new[1]; m_irq = ctrl_new[2];
               end
               3'd1: begin
                  ctrl_new = merge({16'h0, m_presc}, m_wdata, m_wstrb);
                  m_presc = ctrl_new[15:0];
                  m_psc = 0;
               end
               3'd2: m_cnt = merge(m_cnt, m_wdata, m_wstrb);
               3'd3: m_cmp = merge(m_cmp, m_wdata, m_wstrb);
               3'd4: if (m_wdata[0] && m_wstrb[0] && !match) m_pend = 0;
               default: ;
            endcase
            wr_q.push_back(m_aw_idx <= 3'd4 ? 2'b00 : 2'b10);
            m_aw_got = 0; m_w_got = 0;
         end
      end
   end

   // Monitor: pop expected responses on each completed B/R handshake
   bit prev_bv, prev_br, prev_rv, prev_rr;
   always @(negedge clk) begin
      logic [1:0] eb;
      rsp_t       er;
      if (!rst_n) begin
         prev_bv = 0; prev_br = 0; prev_rv = 0; prev_rr = 0;
      end else begin
         if (prev_bv && !prev_br) chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
         if (prev_rv && !prev_rr) chk("rvalid_hold", 32'(bus.rvalid), 32'd1);
         if (bus.bvalid && bus.bready) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL bresp_unexpected at %0t: got bvalid expected none", $time);
            end else begin
               eb = wr_q.pop_front();
               chk("bresp", 32'(bus.bresp), 32'(eb));
            end
         end
         if (bus.rvalid && bus.rready) begin
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rresp_unexpected at %0t: got rvalid expected none", $time);
            end else begin
               er = rd_q.pop_front();
               chk("rdata", bus.rdata, er.data);
               chk("rresp", 32'(bus.rresp), 32'(er.resp));
            end
         end
         prev_bv = bus.bvalid; prev_br = bus.bready;
         prev_rv = bus.rvalid; prev_rr = bus.rready;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done = 0, w_done = 0, b_done = 0;
      int cyc = 0;
      bus.awaddr = addr; bus.awprot = 3'($urandom);
      bus.wdata = data; bus.wstrb = strb;
      while (!(aw_done && w_done) && cyc < 100) begin
         bus.awvalid = !aw_done && (cyc >= aw_dly);
         bus.wvalid  = !w_done && (cyc >= w_dly);
         @(negedge clk);
         if (bus.awvalid && bus.awready) aw_done = 1;
         if (bus.wvalid && bus.wready) w_done = 1;
         @(posedge clk); #1; cyc++;
      end
      bus.awvalid = 0; bus.wvalid = 0;
      cyc = 0;
      while (aw_done && w_done && !b_done && cyc < 100) begin
         bus.bready = (cyc >= b_dly);
         @(negedge clk);
         if (bus.bvalid && bus.bready) b_done = 1;
         @(posedge clk); #1; cyc++;
      end
      bus.bready = 0;
      chk("write_done", 32'(b_done), 32'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_dly);
      bit a_done = 0, r_done = 0;
      int cyc = 0;
      bus.araddr = addr; bus.arprot = 3'($urandom);
      while (!a_done && cyc < 100) begin
         bus.arvalid = 1;
         @(negedge clk);
         if (bus.arvalid && bus.arready) a_done = 1;
         @(posedge clk); #1; cyc++;
      end
      bus.arvalid = 0;
      cyc = 0;
      while (a_done && !r_done && cyc < 100) begin
         bus.rready = (cyc >= r_dly);
         @(negedge clk);
         if (bus.rvalid && bus.rready) r_done = 1;
         @(posedge clk); #1; cyc++;
      end
      bus.rready = 0;
      chk("read_done", 32'(r_done), 32'd1);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      axi_write(addr, data, 4'hF, 0, 0, 0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog at %0t: got no finish expected finish", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [2:0]  idx;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", 32'(bus.awready), 0);
      chk("rst_wready",  32'(bus.wready), 0);
      chk("rst_arready", 32'(bus.arready), 0);
      chk("rst_bvalid",  32'(bus.bvalid), 0);
      chk("rst_rvalid",  32'(bus.rvalid), 0);
      chk("rst_int",     32'(int_o), 0);
      @(posedge clk); #1;
      rst_n = 1;
      idle(2);

      // Reset values of every mapped offset, plus one unmapped read
      for (int i = 0; i <= 4; i++) axi_read(32'(i * 4), i % 3);
      axi_read(32'h18, 1);

      // Auto-reload, tick every cycle, period 5
      wr(32'h04, 0); wr(32'h0C, 4); wr(32'h00, 7);
      idle(23);
      axi_read(32'h08, 0);
      axi_read(32'h10, 0);

      // One-shot with prescaler 3, compare 2
      wr(32'h00, 0); wr(32'h10, 1); wr(32'h08, 0);
      wr(32'h04, 3); wr(32'h0C, 2); wr(32'h00, 5);
      idle(20);
      axi_read(32'h00, 0); axi_read(32'h08, 0); axi_read(32'h10, 0);
      idle(10);
      axi_read(32'h08, 2);

      // W1C at sweeping offsets relative to the match cycle
      wr(32'h00, 0); wr(32'h10, 1); wr(32'h08, 0);
      wr(32'h04, 0); wr(32'h0C, 4); wr(32'h00, 7);
      for (int dly = 0; dly < 7; dly++) begin
         idle(dly);
         wr(32'h10, 1);
         axi_read(32'h10, 0);
      end

      // Counter wrap through 0xFFFFFFFF
      wr(32'h00, 0); wr(32'h10, 1); wr(32'h04, 0); wr(32'h0C, 1);
      wr(32'h08, 32'hFFFF_FFFE); wr(32'h00, 5);
      axi_read(32'h08, 0);
      idle(6);
      axi_read(32'h08, 0); axi_read(32'h10, 0); axi_read(32'h00, 0);

      // Handshake stress and byte strobes
      wr(32'h00, 0); wr(32'h10, 1);
      axi_write(32'h0C, 32'h0, 4'hF, 3, 0, 4);
      axi_write(32'h0C, 32'hAABB_CCDD, 4'h1, 0, 2, 0);
      axi_read(32'h0C, 0);
      axi_write(32'h18, 32'h1234_5678, 4'hF, 1, 0, 1);
      axi_read(32'h18, 0);

      // Random traffic with small timer constants so events occur often
      for (int n = 0; n < 200; n++) begin
         idx = 3'($urandom_range(0, 7));
         a = $urandom();
         a[4:2] = idx;
         case (idx)
            3'd0: d = $urandom_range(0, 15);
            3'd1: d = $urandom_range(0, 3);
            3'd2: d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 6))
                                                  : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            3'd3: d = $urandom_range(0, 6);
            default: d = $urandom();
         endcase
         s = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
         if ($urandom_range(0, 1) == 1)
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read(a, $urandom_range(0, 3));
         idle($urandom_range(0, 4));
      end

      idle(10);
      chk("queues_drained", 32'(rd_q.size() + wr_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
